// File: rtl/coef_table_loader.sv
// rtl/coef_table_loader.sv - writable twiddle-coefficient table with streamed load and registered read
//
// Purpose:
//   Accepts DEPTH coefficient words over a valid/ready handshake, stores them
//   in a DEPTH x WIDTH table and serves them through a one-cycle registered
//   read port that matches the fixed coefficient ROMs.
//
// Optional feature (macro COEF_LOAD_CHECKSUM_EN):
//   defined     - each load carries one extra beat, the mod-2^WIDTH sum of the
//                 DEPTH coefficients; a mismatch raises the sticky err flag.
//   not defined - loads are exactly DEPTH beats, err is tied to 0.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          asynchronous active-high reset
//   start        one-cycle pulse, begins (or restarts) a load
//   in_data      coefficient word
//   in_valid     in_data valid
//   in_ready     block accepts in_data this cycle
//   loading      load in progress
//   done         one-cycle pulse when a load completes
//   err          sticky checksum error (cleared by start)
//   table_valid  table holds a complete load
//   rd_en        read enable
//   rd_addr      read address
//   rd_data      registered read data (holds when rd_en=0)

module coef_table_loader #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             loading,
   output logic             done,
   output logic             err,
   output logic             table_valid,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

`ifdef COEF_LOAD_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2, FIN = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FIN = 2'd3} state_t;
`endif

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t           state;
   logic [AW-1:0]    idx;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_en;

`ifdef COEF_LOAD_CHECKSUM_EN
   logic [WIDTH-1:0] sum;
`endif

   // A start in LOAD restarts the load, so the beat offered alongside it is dropped.
   assign wr_en = (state == LOAD) && in_valid && !start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         in_ready    <= 1'b0;
         loading     <= 1'b0;
         done        <= 1'b0;
         table_valid <= 1'b0;
`ifdef COEF_LOAD_CHECKSUM_EN
         sum         <= '0;
         err         <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= LOAD;
                  idx         <= '0;
                  table_valid <= 1'b0;
                  in_ready    <= 1'b1;
                  loading     <= 1'b1;
`ifdef COEF_LOAD_CHECKSUM_EN
                  sum         <= '0;
                  err         <= 1'b0;
`endif
               end
            end

            LOAD: begin
               if (start) begin
                  idx <= '0;
`ifdef COEF_LOAD_CHECKSUM_EN
                  sum <= '0;
                  err <= 1'b0;
`endif
               end else if (in_valid) begin
`ifdef COEF_LOAD_CHECKSUM_EN
                  sum <= sum + in_data;
`endif
                  // idx never wraps: the last beat moves the FSM on instead.
                  if (idx == LAST_IDX) begin
`ifdef COEF_LOAD_CHECKSUM_EN
                     state <= CHECK;
`else
                     state       <= FIN;
                     in_ready    <= 1'b0;
                     loading     <= 1'b0;
                     done        <= 1'b1;
                     table_valid <= 1'b1;
`endif
                  end else begin
                     idx <= idx + AW'(1);
                  end
               end
            end

`ifdef COEF_LOAD_CHECKSUM_EN
            CHECK: begin
               if (start) begin
                  state <= LOAD;
                  idx   <= '0;
                  sum   <= '0;
                  err   <= 1'b0;
               end else if (in_valid) begin
                  // Checksum beat: compared only, never written to the table.
                  if (in_data != sum)
                     err <= 1'b1;
                  state       <= FIN;
                  in_ready    <= 1'b0;
                  loading     <= 1'b0;
                  done        <= 1'b1;
                  table_valid <= 1'b1;
               end
            end
`endif

            FIN: begin
               // start is ignored here; done was raised on entry and drops now.
               state <= IDLE;
            end

            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               loading  <= 1'b0;
            end
         endcase
      end
   end

`ifndef COEF_LOAD_CHECKSUM_EN
   assign err = 1'b0;
`endif

   // Table storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[idx] <= in_data;
   end

   // Registered read; a same-address write in the same cycle returns the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_coef_table_loader.sv
// tb/tb_coef_table_loader.sv - self-checking bench for coef_table_loader

module tb_coef_table_loader;

`ifdef COEF_LOAD_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif
   localparam int NBEATS = 32 + CK;
   localparam logic [15:0] GOOD_CK = 16'h4fa2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, in_valid, rd_en;
   logic [15:0] in_data;
   logic [4:0]  rd_addr;
   logic        in_ready, loading, done, err, table_valid;
   logic [15:0] rd_data;

   coef_table_loader dut (
      .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .loading(loading), .done(done), .err(err),
      .table_valid(table_valid), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: phase 0 idle, 1 loading, 2 finishing
   int          m_phase;
   int          m_cnt;
   logic [15:0] m_sum;
   logic [15:0] m_mem [32];
   bit          m_known [32];
   bit          m_tv, m_err, m_done, m_acc, m_rd_ok;
   logic [15:0] m_rd;

   typedef struct {
      logic [4:0]  addr;
      logic [15:0] word;
      logic [15:0] exp_rd;
   } vec_t;
   vec_t        vecs [32];
   logic [15:0] cur_words [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      m_acc  = 0;
      m_done = 0;
      if (rd_en) begin
         m_rd_ok = m_known[rd_addr];
         m_rd    = m_mem[rd_addr];
      end
      if (m_phase == 2) begin
         m_phase = 0;
      end else if (start) begin
         if (m_phase == 0) m_tv = 0;
         m_phase = 1;
         m_cnt   = 0;
         m_sum   = 0;
         m_err   = 0;
      end else if (m_phase == 1 && in_valid) begin
         m_acc = 1;
         if (m_cnt < 32) begin
            m_mem[m_cnt]   = in_data;
            m_known[m_cnt] = 1;
            m_sum          = m_sum + in_data;
         end else begin
            m_err = (in_data != m_sum);
         end
         m_cnt++;
         if (m_cnt == NBEATS) begin
            m_phase = 2;
            m_tv    = 1;
            m_done  = 1;
         end
      end
   endtask

   task automatic check_outputs();
      chk("in_ready",    32'(in_ready),    32'(m_phase == 1));
      chk("loading",     32'(loading),     32'(m_phase == 1));
      chk("done",        32'(done),        32'(m_done));
      chk("err",         32'(err),         32'(m_err));
      chk("table_valid", 32'(table_valid), 32'(m_tv));
      if (m_rd_ok) chk("rd_data", 32'(rd_data), 32'(m_rd));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   function automatic logic [15:0] sum_words();
      logic [15:0] s = 16'h0;
      for (int k = 0; k < 32; k++) s = s + cur_words[k];
      return s;
   endfunction

   task automatic randomize_words();
      for (int k = 0; k < 32; k++) cur_words[k] = 16'($urandom);
   endtask

   // Runs one load of cur_words (+ checksum cks). abort_at >= 0 stops after that many beats.
   task automatic run_load(input bit rnd, input logic [15:0] cks, input int abort_at, input bit valid_with_start);
      int i = 0;
      int guard = 0;
      int hs = 0;
      start    = 1'b1;
      in_valid = valid_with_start;
      in_data  = 16'hdead;
      tick();
      start = 1'b0;
      while (i < NBEATS && guard < 3000) begin
         in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = (i < 32) ? cur_words[i] : cks;
         rd_en    = 1'($urandom_range(0, 1));
         rd_addr  = rnd ? 5'($urandom) : 5'(i);
         #1;
         if (in_valid && in_ready) hs++;
         tick();
         if (m_acc) i++;
         guard++;
         if (abort_at >= 0 && i == abort_at) break;
      end
      in_valid = 1'b0;
      rd_en    = 1'b0;
      if (abort_at < 0) begin
         chk("beats_accepted", 32'(i), 32'(NBEATS));
         chk("handshakes", 32'(hs), 32'(NBEATS));
         tick();
      end
   endtask

   initial begin
      logic [15:0] head [9];
      head = '{16'h7fff, 16'hca17, 16'hbfb6, 16'h4f4f, 16'hf5bf, 16'h0090, 16'h002e, 16'h0009, 16'h0001};
      for (int k = 0; k < 32; k++) begin
         vecs[k].addr   = 5'(k);
         vecs[k].word   = 16'h0000;
         vecs[k].exp_rd = 16'h0000;
         if (k < 9) begin
            vecs[k].word   = head[k];
            vecs[k].exp_rd = head[k];
         end
         m_known[k] = 0;
      end

      // Reset state
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0; rd_en = 1'b0; rd_addr = 5'd0;
      m_phase = 0; m_cnt = 0; m_sum = 0; m_tv = 0; m_err = 0; m_done = 0; m_acc = 0;
      m_rd = 16'h0; m_rd_ok = 1;
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;
      repeat (2) tick();

      // Fixed table load with correct checksum, then readback
      for (int k = 0; k < 32; k++) cur_words[k] = vecs[k].word;
      run_load(1'b0, GOOD_CK, -1, 1'b0);
      for (int k = 0; k < 32; k++) begin
         rd_en   = 1'b1;
         rd_addr = vecs[k].addr;
         tick();
         chk("table_rd", 32'(rd_data), 32'(vecs[k].exp_rd));
      end
      rd_en = 1'b0;

      // Same load with a wrong checksum; err stays until the next start
      run_load(1'b0, 16'h1234, -1, 1'b0);
      repeat (3) tick();
      chk("err_sticky", 32'(err), 32'(CK));

      // Random valid pattern with random reads (starts over the pending state)
      randomize_words();
      run_load(1'b1, sum_words(), -1, 1'b0);
      for (int k = 0; k < 16; k++) begin
         rd_en   = 1'b1;
         rd_addr = 5'($urandom);
         tick();
      end
      rd_en = 1'b0;

      // Restart after 10 beats; beat offered with start is dropped
      randomize_words();
      run_load(1'b0, sum_words(), 10, 1'b0);
      randomize_words();
      run_load(1'b0, sum_words(), -1, 1'b1);
      for (int k = 0; k < 32; k++) begin
         rd_en   = 1'b1;
         rd_addr = 5'(k);
         tick();
         chk("restart_rd", 32'(rd_data), 32'(cur_words[k]));
      end
      rd_en = 1'b0;

      // Asynchronous reset at beat 20
      randomize_words();
      run_load(1'b0, sum_words(), 20, 1'b0);
      rst = 1'b1;
      #1;
      m_phase = 0; m_cnt = 0; m_sum = 0; m_tv = 0; m_err = 0; m_done = 0;
      m_rd = 16'h0; m_rd_ok = 1;
      check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd_en   = 1'b1;
      rd_addr = 5'd5;
      tick();
      chk("rd_after_rst", 32'(rd_data), 32'(cur_words[5]));
      rd_en = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/coef_table_loader.md
# coef_table_loader

Writable twiddle-coefficient table for the FFT datapath. It accepts a stream of 16-bit coefficient words over a valid/ready handshake, stores them in a DEPTH-entry table and serves them through a registered read port. Its read side matches the fixed coefficient ROMs, so coefficients can be reloaded at run time instead of being synthesised in. The block sits between the host/config path (writer) and the butterfly coefficient fetch (reader).

## Interface
- DEPTH, 32, number of table entries (power of two)
- WIDTH, 16, coefficient width (Q1.15 two's complement)
- AW, 5, address width, $clog2(DEPTH)
- clk  input  1  single clock, all logic on posedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a new load
- in_data  input  WIDTH  coefficient word
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- loading  output  1  load in progress
- done  output  1  one-cycle pulse when a load completes
- err  output  1  sticky checksum error (macro only; tied 0 otherwise)
- table_valid  output  1  table holds a complete load
- rd_en  input  1  read enable
- rd_addr  input  AW  read address
- rd_data  output  WIDTH  registered read data

## Operation
- FSM states: IDLE, LOAD, CHECK (CHECK exists only with the macro), FIN.
- IDLE: in_ready=0. On start: go to LOAD, idx=0, sum=0, table_valid=0, err=0.
- LOAD: in_ready=1. A beat is accepted when in_valid && in_ready. On each accepted beat: write mem[idx]=in_data, sum+=in_data (mod 2^WIDTH), idx++.
- When the beat with idx==DEPTH-1 is accepted: go to CHECK with the macro, otherwise go to FIN.
- CHECK: in_ready=1. The next accepted beat is the checksum word and is not written to mem. If it is not equal to sum, set err=1. Go to FIN.
- FIN: done=1 for one cycle, table_valid=1 (also set when err=1), then go to IDLE.
- start while in LOAD or CHECK: restart the load. idx=0, sum=0, err=0. Any beat offered in the same cycle is dropped.
- start while in FIN: ignored.
- loading=1 in LOAD and CHECK.
- Read port: when rd_en=1, rd_data <= mem[rd_addr] on the next edge. When rd_en=0, rd_data holds its value.
- A read during a load returns the current mem content.
- Read and write to the same address in the same cycle: rd_data returns the old value (read-before-write).
- mem is not reset. Contents are undefined until the first completed load.

## Timing
- Reset values: in_ready=0, loading=0, done=0, err=0, table_valid=0, rd_data=0, state=IDLE, idx=0, sum=0.
- start at edge N: in_ready=1 from cycle N+1.
- Minimum load time: DEPTH back-to-back beats, +1 checksum beat with the macro, then done in the following cycle.
- Read latency: 1 cycle (address at edge N, data valid after edge N+1).
- rst asserted mid-load: the FSM returns to IDLE immediately and table_valid=0. Partially written mem entries are left as they are.
- The idx counter does not wrap; the FSM leaves LOAD on the last beat.

## Configuration
- COEF_LOAD_CHECKSUM_EN defined: CHECK state present. Each load expects DEPTH+1 beats, the last being the mod-2^WIDTH sum of the DEPTH coefficients. err is reported.
- Not defined: no CHECK state and no sum register. Loads are exactly DEPTH beats and err is tied to 0.

## Test plan
- Reset then idle: all outputs 0. rd_en=1 with rd_addr=0 gives rd_data=0 until a write occurs. start followed by in_ready=1 one cycle later.
- Load 32 words (0x7fff, 0xca17, 0xbfb6, 0x4f4f, 0xf5bf, 0x0090, 0x002e, 0x0009, 0x0001, then 23 × 0x0000) plus the correct checksum -> done pulses once, table_valid=1, err=0. Reading addresses 0..31 returns the same words with 1-cycle latency.
- Same load with checksum 0x1234 (wrong) -> done=1, err=1, table_valid=1. err stays 1 until the next start.
- in_valid toggling 50% with a random pattern -> only beats with in_valid && in_ready are written, in order. Exactly 33 beats are accepted (32 without the macro).
- start asserted after 10 beats -> restart. The next 32 beats overwrite addresses 0..31 and done arrives only after the full new load.
- rst asserted at beat 20 -> loading=0, table_valid=0, in_ready=0 on the same cycle. A read of address 5 returns the word written before reset.
